// File: rtl/demux_key_stream_pkg.sv
// Shared defaults and payload-slicing helper for the key-routed stream demux
// and the MuxKey-style consumers that unpack its flat out_data bus.
package demux_key_stream_pkg;

  localparam int DEFAULT_NR_OUT   = 4;
  localparam int DEFAULT_SEL_LEN  = 2;
  localparam int DEFAULT_DATA_LEN = 8;
  localparam int DEFAULT_CNT_LEN  = 8;

  // Low bit of payload n inside a flat bus of w-bit payloads.
  function automatic int slice_lo(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/demux_key_stream_if.sv
// Valid/ready input stream plus NR_OUT valid/ready output slots of the key demux.
interface demux_key_stream_if #(
  parameter int NR_OUT   = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 8
);

  logic                         in_valid;
  logic                         in_ready;
  logic [SEL_LEN-1:0]           in_sel;
  logic [DATA_LEN-1:0]          in_data;
  logic [NR_OUT-1:0]            out_valid;
  logic [NR_OUT-1:0]            out_ready;
  logic [NR_OUT*DATA_LEN-1:0]   out_data;

  // master: producer plus consumers; slave: the demux itself
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_key_stream_slot.sv
// One-entry register slot: loads on load, empties on drain unless refilled,
// and keeps its payload while empty.
module demux_slot #(
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                drain,
  input  logic [DATA_LEN-1:0] din,
  output logic                valid,
  output logic [DATA_LEN-1:0] data,
  output logic                ready
);

  // Draining frees the slot in the same cycle, giving full throughput.
  assign ready = ~valid | drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_key_stream.sv
// Registered 1-to-NR_OUT stream demux: a keyed beat lands in its own one-entry
// slot; beats whose key has no slot are sunk and counted.
module demux_key_stream
  import demux_key_stream_pkg::*;
#(
  parameter int NR_OUT   = DEFAULT_NR_OUT,
  parameter int SEL_LEN  = DEFAULT_SEL_LEN,
  parameter int DATA_LEN = DEFAULT_DATA_LEN,
  parameter int CNT_LEN  = DEFAULT_CNT_LEN
) (
  input  logic               clk,
  input  logic               rst,
  demux_key_stream_if.slave  bus,
  output logic [CNT_LEN-1:0] drop_cnt,
  output logic               drop_pulse
);

  logic [NR_OUT-1:0]   sel_hot;
  logic [NR_OUT-1:0]   slot_ready;
  logic [NR_OUT-1:0]   slot_valid;
  logic [NR_OUT-1:0]   load;
  logic [NR_OUT-1:0]   drain;
  logic [DATA_LEN-1:0] slot_data [NR_OUT];
  logic                in_range;
  logic                drop;

  // Key decode; an all-zero vector means the key addresses no slot.
  always_comb begin
    sel_hot = '0;
    for (int n = 0; n < NR_OUT; n++) begin
      if (int'(bus.in_sel) == n) sel_hot[n] = 1'b1;
    end
  end

  assign in_range     = |sel_hot;
  assign bus.in_ready = in_range ? |(sel_hot & slot_ready) : 1'b1;
  assign load         = sel_hot & slot_ready & {NR_OUT{bus.in_valid}};
  assign drain        = slot_valid & bus.out_ready;
  assign drop         = bus.in_valid & ~in_range;

  for (genvar n = 0; n < NR_OUT; n++) begin : g_slot
    demux_slot #(
      .DATA_LEN (DATA_LEN)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[n]),
      .drain (drain[n]),
      .din   (bus.in_data),
      .valid (slot_valid[n]),
      .data  (slot_data[n]),
      .ready (slot_ready[n])
    );
  end

  assign bus.out_valid = slot_valid;

  always_comb begin
    bus.out_data = '0;
    for (int n = 0; n < NR_OUT; n++) begin
      bus.out_data[slice_lo(n, DATA_LEN) +: DATA_LEN] = slot_data[n];
    end
  end

  // Drop counter sticks at all-ones, but the pulse still fires on every drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != {CNT_LEN{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_key_stream.sv
// Drives a 4-slot and a 3-slot demux with identical stimulus and checks both
// against a per-slot array model of the routing, drain and drop rules.
module tb_demux_key_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic [3:0] out_ready;

  always #5 clk = ~clk;

  demux_key_stream_if #(.NR_OUT(4), .SEL_LEN(2), .DATA_LEN(8)) bus4 ();
  demux_key_stream_if #(.NR_OUT(3), .SEL_LEN(2), .DATA_LEN(8)) bus3 ();

  assign bus4.in_valid  = in_valid;
  assign bus4.in_sel    = in_sel;
  assign bus4.in_data   = in_data;
  assign bus4.out_ready = out_ready;
  assign bus3.in_valid  = in_valid;
  assign bus3.in_sel    = in_sel;
  assign bus3.in_data   = in_data;
  assign bus3.out_ready = out_ready[2:0];

  logic [7:0] cnt4, cnt3;
  logic       pulse4, pulse3;

  demux_key_stream #(.NR_OUT(4), .SEL_LEN(2), .DATA_LEN(8), .CNT_LEN(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus4.slave),
    .drop_cnt   (cnt4),
    .drop_pulse (pulse4)
  );

  demux_key_stream #(.NR_OUT(3), .SEL_LEN(2), .DATA_LEN(8), .CNT_LEN(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus3.slave),
    .drop_cnt   (cnt3),
    .drop_pulse (pulse3)
  );

  // Reference model, index 0 = 4-slot instance, index 1 = 3-slot instance
  int         nr [2] = '{4, 3};
  bit         mv [2][4];
  logic [7:0] md [2][4];
  int         mc [2];
  bit         mp [2];

  int checks = 0;
  int errors = 0;
  bit ready_known = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit expReady(input int d);
    if (int'(in_sel) >= nr[d]) return 1'b1;
    return !mv[d][in_sel] || out_ready[in_sel];
  endfunction

  task automatic compareState();
    logic [3:0]  ev [2];
    logic [31:0] ed [2];
    for (int d = 0; d < 2; d++) begin
      ev[d] = '0;
      ed[d] = '0;
      for (int n = 0; n < nr[d]; n++) begin
        ev[d][n]       = mv[d][n];
        ed[d][n*8 +: 8] = md[d][n];
      end
    end
    checkOutput("out_valid4", bus4.out_valid, ev[0]);
    checkOutput("out_data4",  bus4.out_data,  ed[0]);
    checkOutput("drop_cnt4",  cnt4,           mc[0]);
    checkOutput("drop_pulse4", pulse4,        mp[0]);
    checkOutput("out_valid3", bus3.out_valid, ev[1]);
    checkOutput("out_data3",  bus3.out_data,  ed[1][23:0]);
    checkOutput("drop_cnt3",  cnt3,           mc[1]);
    checkOutput("drop_pulse3", pulse3,        mp[1]);
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check after posedge.
  task automatic applyStimulus(input bit r, input bit v, input int s, input int dat,
                               input logic [3:0] ord);
    bit rdy [2];
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_sel    = s[1:0];
    in_data   = dat[7:0];
    out_ready = ord;
    #1;
    rdy[0] = expReady(0);
    rdy[1] = expReady(1);
    if (ready_known) begin
      checkOutput("in_ready4", bus4.in_ready, rdy[0]);
      checkOutput("in_ready3", bus3.in_ready, rdy[1]);
    end
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int n = 0; n < 4; n++) begin
          mv[d][n] = 1'b0;
          md[d][n] = 8'h00;
        end
        mc[d] = 0;
        mp[d] = 1'b0;
      end else begin
        mp[d] = 1'b0;
        for (int n = 0; n < nr[d]; n++)
          if (mv[d][n] && out_ready[n]) mv[d][n] = 1'b0;
        if (v) begin
          if (int'(in_sel) >= nr[d]) begin
            if (mc[d] < 255) mc[d]++;
            mp[d] = 1'b1;
          end else if (rdy[d]) begin
            mv[d][in_sel] = 1'b1;
            md[d][in_sel] = in_data;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    compareState();
    ready_known = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;

    // Reset held two cycles with a beat pending
    applyStimulus(1, 1, 2, 'h5A, 4'h0);
    applyStimulus(1, 1, 2, 'h5A, 4'h0);
    checkOutput("rst_valid", bus4.out_valid, 4'b0000);

    // Single route to slot 2, held, then drained
    applyStimulus(0, 1, 2, 'hA5, 4'h0);
    checkOutput("route_valid", bus4.out_valid, 4'b0100);
    checkOutput("route_data", bus4.out_data[23:16], 8'hA5);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 'h00, 4'h0);
    applyStimulus(0, 0, 0, 'h00, 4'b0100);
    checkOutput("drain_valid", bus4.out_valid, 4'b0000);

    // Backpressure on slot 1 must not block slot 3
    applyStimulus(0, 1, 1, 'h11, 4'h0);
    applyStimulus(0, 1, 1, 'h22, 4'h0);
    applyStimulus(0, 1, 3, 'h33, 4'h0);
    checkOutput("bp_slot1", bus4.out_data[15:8], 8'h11);
    checkOutput("bp_slot3", bus4.out_data[31:24], 8'h33);
    applyStimulus(0, 0, 0, 'h00, 4'hF);

    // Back-to-back beats into slot 0 with continuous drain
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, i, 4'hF);
      checkOutput("tput_slot0", bus4.out_data[7:0], i);
    end

    // Key 3 is out of range on the 3-slot instance: drops until saturation
    for (int i = 0; i < 260; i++) applyStimulus(0, 1, 3, i, 4'hF);
    checkOutput("drop_sat", cnt3, 8'd255);
    checkOutput("drop_pulse_sat", pulse3, 1'b1);

    // Reset while slots 0,1 are full and slot 2 is being loaded
    applyStimulus(0, 0, 0, 'h00, 4'hF);
    applyStimulus(0, 1, 0, 'h01, 4'h0);
    applyStimulus(0, 1, 1, 'h02, 4'h0);
    applyStimulus(1, 1, 2, 'h77, 4'h0);
    checkOutput("midrst_valid", bus4.out_valid, 4'b0000);
    checkOutput("midrst_cnt", cnt3, 8'd0);
    applyStimulus(0, 1, 2, 'h88, 4'h0);
    checkOutput("post_rst_route", bus4.out_data[23:16], 8'h88);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3), $urandom_range(0, 255), 4'($urandom_range(0, 15)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
